// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode, alu_op and state encodings shared by the multicycle controller
package isa_pkg;

  localparam int OPC_W   = 4;
  localparam int ALUOP_W = 3;

  localparam logic [OPC_W-1:0] OPC_ADD  = 4'd0;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'd1;
  localparam logic [OPC_W-1:0] OPC_AND  = 4'd2;
  localparam logic [OPC_W-1:0] OPC_OR   = 4'd3;
  localparam logic [OPC_W-1:0] OPC_ADDI = 4'd4;
  localparam logic [OPC_W-1:0] OPC_LW   = 4'd5;
  localparam logic [OPC_W-1:0] OPC_SW   = 4'd6;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 4'd7;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'd8;
  localparam logic [OPC_W-1:0] OPC_HLT  = 4'd15;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_ADDI  = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_JMP   = 3'd5,
    CLS_HLT   = 3'd6,
    CLS_ILL   = 3'd7
  } instr_class_e;

  typedef struct packed {
    instr_class_e         cls;
    logic [ALUOP_W-1:0]   alu_op;
    logic                 alu_src_b;
    logic                 wb_sel;
  } dec_ctrl_t;

  // R-type opcodes 0-3 map one-to-one onto the ALU operation codes.
  function automatic logic [ALUOP_W-1:0] rtype_alu_op(input logic [OPC_W-1:0] opc);
    logic [ALUOP_W-1:0] op;
    case (opc)
      OPC_SUB: op = ALU_SUB;
      OPC_AND: op = ALU_AND;
      OPC_OR:  op = ALU_OR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational opcode to instruction-class and datapath control decode
module control_decode
  import isa_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output dec_ctrl_t        o_ctrl
);

  always_comb begin
    o_ctrl.cls       = CLS_ILL;
    o_ctrl.alu_op    = ALU_ADD;
    o_ctrl.alu_src_b = 1'b0;
    o_ctrl.wb_sel    = 1'b0;
    case (i_opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
        o_ctrl.cls    = CLS_RTYPE;
        o_ctrl.alu_op = rtype_alu_op(i_opcode);
      end
      OPC_ADDI: begin
        o_ctrl.cls       = CLS_ADDI;
        o_ctrl.alu_src_b = 1'b1;
      end
      OPC_LW: begin
        o_ctrl.cls       = CLS_LW;
        o_ctrl.alu_src_b = 1'b1;
        o_ctrl.wb_sel    = 1'b1;
      end
      OPC_SW: begin
        o_ctrl.cls       = CLS_SW;
        o_ctrl.alu_src_b = 1'b1;
      end
      OPC_BEQ: begin
        o_ctrl.cls    = CLS_BEQ;
        o_ctrl.alu_op = ALU_SUB;
      end
      OPC_JMP: o_ctrl.cls = CLS_JMP;
      OPC_HLT: o_ctrl.cls = CLS_HLT;
      default: o_ctrl.cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory wait timeout and halt handling
module multicycle_control
  import isa_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic [2:0]  alu_op,
  output logic        alu_src_b,
  output logic        wb_sel,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  localparam int              CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

  state_e          r_state;
  state_e          w_next;
  logic [CW-1:0]   r_wait;
  logic            r_bus_err;
  logic            r_run_q;

  dec_ctrl_t       w_ctrl;
  logic            w_run_rise;
  logic            w_wait_last;
  logic            w_set_bus_err;
  logic            w_clr_bus_err;
  logic            w_unused_fields;

  logic            w_mem_req;
  logic            w_mem_write;
  logic            w_ir_write;
  logic            w_pc_write;
  logic            w_pc_src;
  logic            w_reg_write;
  logic [2:0]      w_alu_op;
  logic            w_alu_src_b;
  logic            w_wb_sel;
  logic            w_illegal;

  // Register fields are consumed by the datapath, only the opcode steers control.
  assign w_unused_fields = ^instr[11:0];

  control_decode u_decode (
    .i_opcode (instr[15:12]),
    .o_ctrl   (w_ctrl)
  );

  assign w_run_rise  = run & ~r_run_q;
  assign w_wait_last = (r_wait == WAIT_LAST) & ~mem_ready;

  always_comb begin
    w_next        = r_state;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_op      = ALU_ADD;
    w_alu_src_b   = 1'b0;
    w_wb_sel      = 1'b0;
    w_illegal     = 1'b0;
    w_set_bus_err = 1'b0;
    w_clr_bus_err = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (run) begin
          w_mem_req = 1'b1;
          if (mem_ready) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            w_next     = ST_DECODE;
          end else if (w_wait_last) begin
            w_set_bus_err = 1'b1;
            w_next        = ST_HALT;
          end
        end
      end
      ST_DECODE: begin
        case (w_ctrl.cls)
          CLS_HLT: w_next = ST_HALT;
          CLS_ILL: begin
            w_illegal = 1'b1;
            w_next    = ST_FETCH;
          end
          default: w_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        w_alu_op    = w_ctrl.alu_op;
        w_alu_src_b = w_ctrl.alu_src_b;
        case (w_ctrl.cls)
          CLS_RTYPE, CLS_ADDI: w_next = ST_WB;
          CLS_LW, CLS_SW:      w_next = ST_MEM;
          CLS_BEQ: begin
            w_pc_write = zero;
            w_pc_src   = zero;
            w_next     = ST_FETCH;
          end
          CLS_JMP: begin
            w_pc_write = 1'b1;
            w_pc_src   = 1'b1;
            w_next     = ST_FETCH;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_write = (w_ctrl.cls == CLS_SW);
        if (mem_ready) begin
          w_next = (w_ctrl.cls == CLS_LW) ? ST_WB : ST_FETCH;
        end else if (w_wait_last) begin
          w_set_bus_err = 1'b1;
          w_next        = ST_HALT;
        end
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = w_ctrl.wb_sel;
        w_next      = ST_FETCH;
      end
      ST_HALT: begin
        if (w_run_rise) begin
          w_clr_bus_err = 1'b1;
          w_next        = ST_FETCH;
        end
      end
      default: w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
      r_run_q   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run_q <= run;
      // Any state change restarts the wait window, so FETCH and MEM always begin at zero.
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_mem_req && !mem_ready) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_set_bus_err) begin
        r_bus_err <= 1'b1;
      end else if (w_clr_bus_err) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  // Outputs are gated by rst_n so an asserted reset silences requests in the same cycle.
  assign mem_req   = rst_n & w_mem_req;
  assign mem_write = rst_n & w_mem_write;
  assign ir_write  = rst_n & w_ir_write;
  assign pc_write  = rst_n & w_pc_write;
  assign pc_src    = rst_n & w_pc_src;
  assign reg_write = rst_n & w_reg_write;
  assign alu_op    = rst_n ? w_alu_op : 3'b000;
  assign alu_src_b = rst_n & w_alu_src_b;
  assign wb_sel    = rst_n & w_wb_sel;
  assign illegal   = rst_n & w_illegal;
  assign halted    = rst_n & (r_state == ST_HALT);
  assign bus_err   = rst_n & r_bus_err;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_write, ir_write, pc_write, pc_src, reg_write;
  logic [2:0]  alu_op;
  logic        alu_src_b, wb_sel, halted, illegal, bus_err;

  multicycle_control #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .illegal   (illegal),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       wb_sel;
    logic       halted;
    logic       illegal;
    logic       bus_err;
  } out_t;

  typedef struct {
    string       name;
    logic        run;
    logic [15:0] instr;
    logic        zero;
    logic        rdy;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic out_t ex_none();
    out_t r;
    r = '0;
    return r;
  endfunction

  function automatic out_t ex_fetch();
    out_t r;
    r = '0;
    r.mem_req  = 1'b1;
    r.ir_write = 1'b1;
    r.pc_write = 1'b1;
    return r;
  endfunction

  function automatic out_t ex_wait();
    out_t r;
    r = '0;
    r.mem_req = 1'b1;
    return r;
  endfunction

  function automatic out_t ex_exec(logic [2:0] op, logic srcb, logic pcw);
    out_t r;
    r = '0;
    r.alu_op    = op;
    r.alu_src_b = srcb;
    r.pc_write  = pcw;
    r.pc_src    = pcw;
    return r;
  endfunction

  function automatic out_t ex_mem(logic wr);
    out_t r;
    r = '0;
    r.mem_req   = 1'b1;
    r.mem_write = wr;
    return r;
  endfunction

  function automatic out_t ex_wb(logic sel);
    out_t r;
    r = '0;
    r.reg_write = 1'b1;
    r.wb_sel    = sel;
    return r;
  endfunction

  function automatic out_t ex_halt(logic be);
    out_t r;
    r = '0;
    r.halted  = 1'b1;
    r.bus_err = be;
    return r;
  endfunction

  function automatic out_t ex_ill();
    out_t r;
    r = '0;
    r.illegal = 1'b1;
    return r;
  endfunction

  function automatic out_t actual();
    return {mem_req, mem_write, ir_write, pc_write, pc_src, reg_write,
            alu_op, alu_src_b, wb_sel, halted, illegal, bus_err};
  endfunction

  task automatic add(string n, logic r, logic [15:0] i, logic z, logic rdy, out_t e);
    vecs.push_back('{n, r, i, z, rdy, e});
  endtask

  task automatic add_alu(string n, logic [15:0] i, logic [2:0] op, logic srcb);
    add({n, ".F"}, 1'b1, i, 1'b0, 1'b1, ex_fetch());
    add({n, ".D"}, 1'b1, i, 1'b0, 1'b1, ex_none());
    add({n, ".E"}, 1'b1, i, 1'b0, 1'b1, ex_exec(op, srcb, 1'b0));
    add({n, ".W"}, 1'b1, i, 1'b0, 1'b1, ex_wb(1'b0));
  endtask

  task automatic check(string name);
    out_t a;
    out_t e;
    a = actual();
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry, got %h", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", name, a, e);
      end
    end
  endtask

  task automatic apply(vec_t v);
    run       = v.run;
    instr     = v.instr;
    zero      = v.zero;
    mem_ready = v.rdy;
    exp_q.push_back(v.exp);
    #2;
    check(v.name);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add_alu("add",  16'h0000, 3'b000, 1'b0);
    add_alu("sub",  16'h1000, 3'b001, 1'b0);
    add_alu("and",  16'h2000, 3'b010, 1'b0);
    add_alu("or",   16'h3000, 3'b011, 1'b0);
    add_alu("addi", 16'h4A01, 3'b000, 1'b1);

    add("lw.F", 1'b1, 16'h5A1F, 1'b0, 1'b1, ex_fetch());
    add("lw.D", 1'b1, 16'h5A1F, 1'b0, 1'b1, ex_none());
    add("lw.E", 1'b1, 16'h5A1F, 1'b0, 1'b1, ex_exec(3'b000, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) add("lw.Mwait", 1'b1, 16'h5A1F, 1'b0, 1'b0, ex_mem(1'b0));
    add("lw.M", 1'b1, 16'h5A1F, 1'b0, 1'b1, ex_mem(1'b0));
    add("lw.W", 1'b1, 16'h5A1F, 1'b0, 1'b1, ex_wb(1'b1));

    add("sw.F", 1'b1, 16'h6000, 1'b0, 1'b1, ex_fetch());
    add("sw.D", 1'b1, 16'h6000, 1'b0, 1'b1, ex_none());
    add("sw.E", 1'b1, 16'h6000, 1'b0, 1'b1, ex_exec(3'b000, 1'b1, 1'b0));
    add("sw.M", 1'b1, 16'h6000, 1'b0, 1'b1, ex_mem(1'b1));

    add("beq1.F", 1'b1, 16'h7003, 1'b1, 1'b1, ex_fetch());
    add("beq1.D", 1'b1, 16'h7003, 1'b1, 1'b1, ex_none());
    add("beq1.E", 1'b1, 16'h7003, 1'b1, 1'b1, ex_exec(3'b001, 1'b0, 1'b1));
    add("beq0.F", 1'b1, 16'h7003, 1'b0, 1'b1, ex_fetch());
    add("beq0.D", 1'b1, 16'h7003, 1'b0, 1'b1, ex_none());
    add("beq0.E", 1'b1, 16'h7003, 1'b0, 1'b1, ex_exec(3'b001, 1'b0, 1'b0));

    add("jmp.F", 1'b1, 16'h8000, 1'b0, 1'b1, ex_fetch());
    add("jmp.D", 1'b1, 16'h8000, 1'b0, 1'b1, ex_none());
    add("jmp.E", 1'b1, 16'h8000, 1'b0, 1'b1, ex_exec(3'b000, 1'b0, 1'b1));

    add("illB.F", 1'b1, 16'hB000, 1'b0, 1'b1, ex_fetch());
    add("illB.D", 1'b1, 16'hB000, 1'b0, 1'b1, ex_ill());
    add("illE.F", 1'b1, 16'hE000, 1'b0, 1'b1, ex_fetch());
    add("illE.D", 1'b1, 16'hE000, 1'b0, 1'b1, ex_ill());

    add("idle0", 1'b0, 16'h0000, 1'b0, 1'b1, ex_none());
    add("idle1", 1'b0, 16'h0000, 1'b0, 1'b1, ex_none());

    add("hlt.F",     1'b1, 16'hF000, 1'b0, 1'b1, ex_fetch());
    add("hlt.D",     1'b1, 16'hF000, 1'b0, 1'b1, ex_none());
    add("hlt.Hrun",  1'b1, 16'hF000, 1'b0, 1'b1, ex_halt(1'b0));
    add("hlt.Hrun2", 1'b1, 16'hF000, 1'b0, 1'b1, ex_halt(1'b0));
    add("hlt.Hlow",  1'b0, 16'hF000, 1'b0, 1'b1, ex_halt(1'b0));
    add("hlt.Hrise", 1'b1, 16'hF000, 1'b0, 1'b1, ex_halt(1'b0));

    for (int k = 0; k < 16; k++) add("to.Fwait", 1'b1, 16'h0000, 1'b0, 1'b0, ex_wait());
    add("to.Herr",  1'b1, 16'h0000, 1'b0, 1'b0, ex_halt(1'b1));
    add("to.Hlow",  1'b0, 16'h0000, 1'b0, 1'b0, ex_halt(1'b1));
    add("to.Hrise", 1'b1, 16'h0000, 1'b0, 1'b0, ex_halt(1'b1));
    add_alu("to.add", 16'h0000, 3'b000, 1'b0);

    rst_n     = 1'b0;
    run       = 1'b1;
    instr     = 16'h0000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    exp_q.push_back(ex_none());
    #2;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k]);

    apply('{"swr.F", 1'b1, 16'h6000, 1'b0, 1'b1, ex_fetch()});
    apply('{"swr.D", 1'b1, 16'h6000, 1'b0, 1'b1, ex_none()});
    apply('{"swr.E", 1'b1, 16'h6000, 1'b0, 1'b1, ex_exec(3'b000, 1'b1, 1'b0)});
    mem_ready = 1'b0;
    exp_q.push_back(ex_mem(1'b1));
    #2;
    check("swr.M");
    #1;
    rst_n = 1'b0;
    exp_q.push_back(ex_none());
    #1;
    check("swr.rst_mid_mem");
    @(negedge clk);
    mem_ready = 1'b1;
    exp_q.push_back(ex_none());
    #2;
    check("swr.rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    apply('{"swr.post_F", 1'b1, 16'h0000, 1'b0, 1'b1, ex_fetch()});
    apply('{"swr.post_D", 1'b1, 16'h0000, 1'b0, 1'b1, ex_none()});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
